// File: rtl/fc_tx_arbiter.sv
// Transmit word arbiter: selects link primitives, user frames or IDLE fill toward the transceiver.
// Latency: one cycle; a word accepted from avtx in cycle N is on tx_data in cycle N+1.
// Backpressure: avtx_ready depends only on arbiter state and link_up, never on avtx_valid.
//
// Ports:
//   clk, reset            tx_clk domain, synchronous active-high reset
//   state, xcvr_ready     link state (pre-synchronised) and transceiver ready, combined into link_up
//   prim_data/_datak      ordered-set word from the TX state logic
//   avtx_*                Avalon-ST sink for user frames (ready latency 0)
//   tx_data/_datak        registered big-endian word to the transceiver
//   frames_sent/underruns 16-bit saturating statistics
//
// Optional statistics: define FC_TX_ARB_STATS_EN to build the counters; otherwise they read 0.

package fc;
  typedef enum logic [3:0] {
    STATE_LF1, STATE_LF2, STATE_OL1, STATE_OL2, STATE_OL3,
    STATE_LR1, STATE_LR2, STATE_LR3, STATE_AC
  } state_t;

  // K28.5 D21.4 D21.5 D21.5
  localparam logic [31:0] IDLE = 32'hBC95_B5B5;
  // K28.5 D21.5 D21.7 D21.7
  localparam logic [31:0] EOFA = 32'hBCB5_F5F5;
endpackage

module fc_tx_arbiter #(
  parameter int unsigned MIN_ENTRY_IDLES = 6,
  parameter int unsigned MIN_GAP_IDLES   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  fc::state_t  state,
  input  logic        xcvr_ready,
  input  logic [31:0] prim_data,
  input  logic [3:0]  prim_datak,
  input  logic [31:0] avtx_data,
  input  logic        avtx_valid,
  input  logic        avtx_startofpacket,
  input  logic        avtx_endofpacket,
  output logic        avtx_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_datak,
  output logic [15:0] frames_sent,
  output logic [15:0] underruns
);

  typedef enum logic [2:0] {
    S_LINK, S_ENTRY, S_OPEN, S_FRAME, S_GAP, S_DRAIN
  } arb_state_t;

  localparam logic [3:0]  K_CTRL     = 4'b1000;
  localparam logic [3:0]  K_DATA     = 4'b0000;
  localparam logic [15:0] ENTRY_LOAD = 16'(MIN_ENTRY_IDLES);
  localparam logic [15:0] GAP_LOAD   = 16'(MIN_GAP_IDLES);
  // A zero-length gap/entry skips straight to OPEN.
  localparam arb_state_t  ENTRY_ST   = (ENTRY_LOAD == 16'd0) ? S_OPEN : S_ENTRY;
  localparam arb_state_t  GAP_ST     = (GAP_LOAD == 16'd0) ? S_OPEN : S_GAP;

  arb_state_t  cur_st, nxt_st;
  logic [15:0] idle_cnt, idle_cnt_nxt;
  logic [31:0] data_nxt;
  logic [3:0]  datak_nxt;
  logic        link_up, xfer, frame_done, frame_abort;
  arb_state_t  post_eop_st;

  assign link_up     = (state == fc::STATE_AC) && xcvr_ready;
  assign xfer        = avtx_valid && avtx_ready;
  // Once an EOP is consumed, a dead link goes back to primitives instead of counting IDLEs.
  assign post_eop_st = link_up ? GAP_ST : S_LINK;

  always_comb begin
    avtx_ready = 1'b0;
    case (cur_st)
      S_OPEN:          avtx_ready = link_up;
      // FRAME/DRAIN keep accepting even after link loss so the source can flush to EOP.
      S_FRAME, S_DRAIN: avtx_ready = 1'b1;
      default:         avtx_ready = 1'b0;
    endcase
  end

  always_comb begin
    nxt_st       = cur_st;
    idle_cnt_nxt = idle_cnt;
    data_nxt     = fc::IDLE;
    datak_nxt    = K_CTRL;
    frame_done   = 1'b0;
    frame_abort  = 1'b0;
    case (cur_st)
      S_LINK: begin
        data_nxt  = prim_data;
        datak_nxt = prim_datak;
        if (link_up) begin
          idle_cnt_nxt = ENTRY_LOAD;
          nxt_st       = ENTRY_ST;
        end
      end
      S_ENTRY, S_GAP: begin
        if (!link_up) begin
          data_nxt  = prim_data;
          datak_nxt = prim_datak;
          nxt_st    = S_LINK;
        end else begin
          idle_cnt_nxt = idle_cnt - 16'd1;
          if (idle_cnt <= 16'd1) nxt_st = S_OPEN;
        end
      end
      S_OPEN: begin
        if (!link_up) begin
          data_nxt  = prim_data;
          datak_nxt = prim_datak;
          nxt_st    = S_LINK;
        end else if (xfer) begin
          if (avtx_startofpacket) begin
            data_nxt = avtx_data;
            if (avtx_endofpacket) begin
              frame_done   = 1'b1;
              idle_cnt_nxt = GAP_LOAD;
              nxt_st       = GAP_ST;
            end else begin
              nxt_st = S_FRAME;
            end
          end else begin
            // Headless word: dropped, line stays IDLE.
            frame_abort = 1'b1;
          end
        end
      end
      S_FRAME: begin
        if (xfer && avtx_startofpacket) begin
          // A new SOP inside a frame means the previous frame lost its tail.
          data_nxt    = fc::EOFA;
          frame_abort = 1'b1;
          if (avtx_endofpacket) begin
            idle_cnt_nxt = GAP_LOAD;
            nxt_st       = post_eop_st;
          end else begin
            nxt_st = S_DRAIN;
          end
        end else if (xfer && avtx_endofpacket) begin
          // EOF wins over a simultaneous link drop: the frame is complete.
          data_nxt     = avtx_data;
          frame_done   = 1'b1;
          idle_cnt_nxt = GAP_LOAD;
          nxt_st       = post_eop_st;
        end else if (!link_up || !avtx_valid) begin
          data_nxt    = fc::EOFA;
          frame_abort = 1'b1;
          nxt_st      = S_DRAIN;
        end else begin
          data_nxt  = avtx_data;
          datak_nxt = K_DATA;
        end
      end
      S_DRAIN: begin
        if (!link_up) begin
          data_nxt  = prim_data;
          datak_nxt = prim_datak;
        end
        if (xfer && avtx_endofpacket) begin
          idle_cnt_nxt = GAP_LOAD;
          nxt_st       = post_eop_st;
        end
      end
      default: nxt_st = S_LINK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st   <= S_LINK;
      idle_cnt <= 16'd0;
      tx_data  <= fc::IDLE;
      tx_datak <= K_CTRL;
    end else begin
      cur_st   <= nxt_st;
      idle_cnt <= idle_cnt_nxt;
      tx_data  <= data_nxt;
      tx_datak <= datak_nxt;
    end
  end

`ifdef FC_TX_ARB_STATS_EN
  logic [15:0] frames_q, underruns_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q    <= 16'd0;
      underruns_q <= 16'd0;
    end else begin
      if (frame_done && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
      if (frame_abort && underruns_q != 16'hFFFF) underruns_q <= underruns_q + 16'd1;
    end
  end

  assign frames_sent = frames_q;
  assign underruns   = underruns_q;
`else
  logic unused_stats;
  assign unused_stats = frame_done ^ frame_abort;
  assign frames_sent  = 16'd0;
  assign underruns    = 16'd0;
`endif

endmodule

// File: tb/tb_fc_tx_arbiter.sv
// Directed bench for fc_tx_arbiter: entry, back-to-back, underrun, link loss, stray data, reset.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
// Counter expectations follow whether FC_TX_ARB_STATS_EN is defined.
module tb_fc_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  fc::state_t  link_state;
  logic        xcvr_ready;
  logic [31:0] prim_data;
  logic [3:0]  prim_datak;
  logic [31:0] avtx_data;
  logic        avtx_valid, avtx_startofpacket, avtx_endofpacket, avtx_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_datak;
  logic [15:0] frames_sent, underruns;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PRIM   = 32'hBC4A_1234;
  localparam logic [3:0]  PRIMK  = 4'b1001;
  localparam logic [35:0] W_IDLE = {4'b1000, 32'hBC95_B5B5};
  localparam logic [35:0] W_EOFA = {4'b1000, 32'hBCB5_F5F5};
  localparam logic [35:0] W_PRIM = {PRIMK, PRIM};

  always #5 clk = ~clk;

  fc_tx_arbiter #(.MIN_ENTRY_IDLES(6), .MIN_GAP_IDLES(6)) dut (
    .clk(clk), .reset(reset), .state(link_state), .xcvr_ready(xcvr_ready),
    .prim_data(prim_data), .prim_datak(prim_datak),
    .avtx_data(avtx_data), .avtx_valid(avtx_valid),
    .avtx_startofpacket(avtx_startofpacket), .avtx_endofpacket(avtx_endofpacket),
    .avtx_ready(avtx_ready), .tx_data(tx_data), .tx_datak(tx_datak),
    .frames_sent(frames_sent), .underruns(underruns)
  );

  function automatic logic [15:0] ec(input int n);
`ifdef FC_TX_ARB_STATS_EN
    return 16'(n);
`else
    return (n > 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e);
    avtx_valid         = v;
    avtx_data          = d;
    avtx_startofpacket = s;
    avtx_endofpacket   = e;
  endtask

  task automatic out_chk(input string tag, input logic [35:0] exp);
    chk(tag, {tx_datak, tx_data}, exp);
  endtask

  task automatic rdy_chk(input string tag, input logic exp);
    chk(tag, 36'(avtx_ready), 36'(exp));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    link_state = fc::STATE_OL1;
    xcvr_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    out_chk("link_prim", W_PRIM);
  endtask

  task automatic entry();
    link_state = fc::STATE_AC;
    rdy_chk("link_rdy", 1'b0);
    step();
    out_chk("entry_link_word", W_PRIM);
    for (int i = 0; i < 6; i++) begin
      rdy_chk("entry_rdy", 1'b0);
      step();
      out_chk("entry_idle", W_IDLE);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    drive(1'b1, d, s, e);
    rdy_chk("word_rdy", 1'b1);
    step();
    out_chk("word_out", {(s || e) ? 4'b1000 : 4'b0000, d});
  endtask

  task automatic send_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      send_word(base + 32'(i), i == 0, i == n - 1);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) begin
      rdy_chk("gap_rdy", 1'b0);
      step();
      out_chk("gap_idle", W_IDLE);
    end
  endtask

  initial begin
    prim_data  = PRIM;
    prim_datak = PRIMK;
    reset      = 1'b1;
    link_state = fc::STATE_OL1;
    xcvr_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    out_chk("rst_tx", W_IDLE);
    rdy_chk("rst_rdy", 1'b0);
    chk("rst_frames", 36'(frames_sent), 36'd0);
    chk("rst_underruns", 36'(underruns), 36'd0);

    // AC without transceiver ready keeps the link in primitives.
    reset = 1'b0;
    link_state = fc::STATE_AC;
    xcvr_ready = 1'b0;
    step();
    out_chk("noxcvr_prim", W_PRIM);
    rdy_chk("noxcvr_rdy", 1'b0);

    // Entry: 6 IDLEs then a 4-word frame.
    do_reset();
    entry();
    send_frame(32'hA000_0000, 4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("entry_frames", 36'(frames_sent), 36'(ec(1)));

    // Back-to-back frames with the source always valid.
    do_reset();
    entry();
    send_frame(32'hB100_0000, 4);
    drive(1'b1, 32'hB200_0000, 1'b1, 1'b0);
    idles(6);
    send_frame(32'hB200_0000, 4);
    drive(1'b1, 32'hB300_0000, 1'b1, 1'b0);
    idles(6);
    send_frame(32'hB300_0000, 4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("b2b_frames", 36'(frames_sent), 36'(ec(3)));

    // Underrun after the 2nd data word.
    do_reset();
    entry();
    send_word(32'hC000_0000, 1'b1, 1'b0);
    send_word(32'hC000_0001, 1'b0, 1'b0);
    send_word(32'hC000_0002, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rdy_chk("urun_rdy", 1'b1);
    step();
    out_chk("urun_eofa", W_EOFA);
    chk("urun_count", 36'(underruns), 36'(ec(1)));
    drive(1'b1, 32'hC000_0003, 1'b0, 1'b0);
    rdy_chk("drain_rdy", 1'b1);
    step();
    out_chk("drain_idle", W_IDLE);
    drive(1'b1, 32'hC000_0004, 1'b0, 1'b1);
    step();
    out_chk("drain_eop_idle", W_IDLE);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    idles(6);
    rdy_chk("urun_open_rdy", 1'b1);
    chk("urun_frames", 36'(frames_sent), 36'(ec(0)));

    // Link loss mid-frame.
    do_reset();
    entry();
    send_word(32'hD000_0000, 1'b1, 1'b0);
    send_word(32'hD000_0001, 1'b0, 1'b0);
    link_state = fc::STATE_OL1;
    drive(1'b1, 32'hD000_0002, 1'b0, 1'b0);
    rdy_chk("loss_rdy0", 1'b1);
    step();
    out_chk("loss_eofa", W_EOFA);
    chk("loss_underruns", 36'(underruns), 36'(ec(1)));
    drive(1'b1, 32'hD000_0003, 1'b0, 1'b0);
    rdy_chk("loss_rdy1", 1'b1);
    step();
    out_chk("loss_prim1", W_PRIM);
    drive(1'b1, 32'hD000_0004, 1'b0, 1'b1);
    rdy_chk("loss_rdy2", 1'b1);
    step();
    out_chk("loss_prim2", W_PRIM);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rdy_chk("loss_rdy_link", 1'b0);
    step();
    out_chk("loss_prim3", W_PRIM);
    chk("loss_frames", 36'(frames_sent), 36'(ec(0)));

    // EOP and link drop in the same cycle: clean EOF, then primitives.
    do_reset();
    entry();
    send_word(32'hE000_0000, 1'b1, 1'b0);
    send_word(32'hE000_0001, 1'b0, 1'b0);
    link_state = fc::STATE_OL1;
    drive(1'b1, 32'hE000_0002, 1'b0, 1'b1);
    step();
    out_chk("sim_eof", {4'b1000, 32'hE000_0002});
    chk("sim_frames", 36'(frames_sent), 36'(ec(1)));
    chk("sim_underruns", 36'(underruns), 36'(ec(0)));
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rdy_chk("sim_rdy", 1'b0);
    step();
    out_chk("sim_prim", W_PRIM);

    // Stray word in OPEN, then an intact frame.
    do_reset();
    entry();
    drive(1'b1, 32'hF0F0_F0F0, 1'b0, 1'b0);
    rdy_chk("stray_rdy", 1'b1);
    step();
    out_chk("stray_idle", W_IDLE);
    chk("stray_underruns", 36'(underruns), 36'(ec(1)));
    send_frame(32'h5100_0000, 4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stray_frames", 36'(frames_sent), 36'(ec(1)));

    // Reset mid-frame: IDLE without EOFa, back in LINK.
    do_reset();
    entry();
    send_word(32'h6000_0000, 1'b1, 1'b0);
    send_word(32'h6000_0001, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 32'h6000_0002, 1'b0, 1'b0);
    step();
    out_chk("midrst_idle", W_IDLE);
    rdy_chk("midrst_rdy", 1'b0);
    reset = 1'b0;
    link_state = fc::STATE_OL1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    out_chk("midrst_prim", W_PRIM);

`ifdef FC_TX_ARB_STATS_EN
    // Stray words every cycle in OPEN drive underruns past saturation.
    do_reset();
    entry();
    drive(1'b1, 32'h7777_7777, 1'b0, 1'b0);
    repeat (65536) step();
    chk("sat_underruns", 36'(underruns), 36'h0_0000_FFFF);
    step();
    chk("sat_hold", 36'(underruns), 36'h0_0000_FFFF);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
